// File: rtl/hazard_fwd_ctrl_pkg.sv
// ============================================================================
// Module      : hazard_fwd_ctrl_pkg
// Description : Shared types and constants for the hazard/forwarding control
//               slice: multiply/divide FSM states, zero-register number and
//               stall-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_fwd_ctrl_pkg;

  // Multiply/divide tracker states
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Register r0 is hardwired to zero and never produces a hazard
  localparam logic [4:0] ZERO_REG = 5'd0;

  // Width of the stall performance counter
  localparam int STALL_CNT_W = 16;

  // Width of the mult/div latency counter (covers latencies up to 63)
  localparam int MD_CNT_W = 6;

endpackage : hazard_fwd_ctrl_pkg

`default_nettype wire

// File: rtl/hazard_md_timer.sv
// ============================================================================
// Module      : hazard_md_timer
// Description : Tracks an in-flight multiply/divide. md_start loads a
//               down-counter with MD_LAT-1; md_busy stays high until the
//               counter has reached zero. A new md_start restarts the count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_md_timer
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int MD_LAT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start,
  output logic md_busy
);

  localparam logic [MD_CNT_W-1:0] RELOAD = MD_CNT_W'(MD_LAT - 1);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;

  // State and counter registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: start/restart reloads, busy counts down, zero returns to idle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (md_start) begin
          state_d = MD_BUSY;
          cnt_d   = RELOAD;
        end
      end
      MD_BUSY: begin
        if (md_start) begin
          cnt_d = RELOAD;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - MD_CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign md_busy = (state_q == MD_BUSY);

endmodule : hazard_md_timer

`default_nettype wire

// File: rtl/hazard_fwd_ctrl.sv
// ============================================================================
// Module      : hazard_fwd_ctrl
// Description : ID-stage hazard detection and EX operand forwarding control
//               for a 5-stage pipeline. Detects load-use and HI/LO-read
//               stalls, resolves taken-branch flushes, registers forwarding
//               selects for EX and counts stall cycles (saturating).
// Config      : HAZ_MULDIV_EN - when defined, a multiply/divide busy tracker
//               stalls MFHI/MFLO until the result is ready. When undefined,
//               md_busy is 0 and md_start/id_reads_hilo are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int MD_LAT = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic                   id_reads_hilo,
  input  logic [4:0]             ex_rd,
  input  logic                   ex_regwrite,
  input  logic                   ex_memread,
  input  logic [4:0]             mem_rd,
  input  logic                   mem_regwrite,
  input  logic                   branch_taken,
  input  logic                   md_start,
  output logic                   fwd_a_mem,
  output logic                   fwd_a_wb,
  output logic                   fwd_b_mem,
  output logic                   fwd_b_wb,
  output logic                   pc_write,
  output logic                   ifid_write,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   md_busy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic ex_match_a, ex_match_b, mem_match_a, mem_match_b;
  logic load_stall, hilo_stall, stall;

  logic fwd_a_mem_q, fwd_a_mem_d, fwd_a_wb_q, fwd_a_wb_d;
  logic fwd_b_mem_q, fwd_b_mem_d, fwd_b_wb_q, fwd_b_wb_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Producer/consumer matches; r0 never forwards and unread sources never match
  assign ex_match_a  = ex_regwrite  && (ex_rd  != ZERO_REG) && (ex_rd  == id_rs) && id_uses_rs;
  assign ex_match_b  = ex_regwrite  && (ex_rd  != ZERO_REG) && (ex_rd  == id_rt) && id_uses_rt;
  assign mem_match_a = mem_regwrite && (mem_rd != ZERO_REG) && (mem_rd == id_rs) && id_uses_rs;
  assign mem_match_b = mem_regwrite && (mem_rd != ZERO_REG) && (mem_rd == id_rt) && id_uses_rt;

  // Load in EX feeding the ID instruction cannot be forwarded in time
  assign load_stall = ex_memread && (ex_match_a || ex_match_b);

`ifdef HAZ_MULDIV_EN
  hazard_md_timer #(
    .MD_LAT   (MD_LAT)
  ) u_md_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .md_start (md_start),
    .md_busy  (md_busy)
  );

  assign hilo_stall = md_busy && id_reads_hilo;
`else
  logic unused_md_inputs;
  assign unused_md_inputs = md_start ^ id_reads_hilo;
  assign md_busy          = 1'b0;
  assign hilo_stall       = 1'b0;
`endif

  // A taken branch squashes the ID instruction, so its stall is moot
  assign stall      = (load_stall || hilo_stall) && !branch_taken;
  assign pc_write   = !stall;
  assign ifid_write = !stall;
  assign idex_flush = stall || branch_taken;
  assign ifid_flush = branch_taken;

  // Forward selects for next EX: youngest producer wins, bubbles forward nothing
  always_comb begin
    fwd_a_mem_d = 1'b0;
    fwd_a_wb_d  = 1'b0;
    fwd_b_mem_d = 1'b0;
    fwd_b_wb_d  = 1'b0;
    if (!idex_flush) begin
      fwd_a_mem_d = ex_match_a;
      fwd_a_wb_d  = mem_match_a && !ex_match_a;
      fwd_b_mem_d = ex_match_b;
      fwd_b_wb_d  = mem_match_b && !ex_match_b;
    end
  end

  // Saturating count of stalled cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  // Registered forwarding selects and stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_mem_q <= 1'b0;
      fwd_a_wb_q  <= 1'b0;
      fwd_b_mem_q <= 1'b0;
      fwd_b_wb_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      fwd_a_mem_q <= fwd_a_mem_d;
      fwd_a_wb_q  <= fwd_a_wb_d;
      fwd_b_mem_q <= fwd_b_mem_d;
      fwd_b_wb_q  <= fwd_b_wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_a_mem = fwd_a_mem_q;
  assign fwd_a_wb  = fwd_a_wb_q;
  assign fwd_b_mem = fwd_b_mem_q;
  assign fwd_b_wb  = fwd_b_wb_q;
  assign stall_cnt = stall_cnt_q;

endmodule : hazard_fwd_ctrl

`default_nettype wire

// File: doc/hazard_fwd_ctrl.md
HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 Parameter: MD_LAT, default 32, multiply/divide latency in cycles (legal range 2..63).
REQ-002 Ports, clock and reset first:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
REQ-003 ID-stage inputs:
- id_rs, id_rt  in  5 each  source register numbers.
- id_uses_rs, id_uses_rt  in  1 each  source actually read.
- id_reads_hilo  in  1  ID instruction is MFHI/MFLO.
REQ-004 Later-stage inputs:
- ex_rd  in  5.
- ex_regwrite, ex_memread  in  1 each.
- mem_rd  in  5.
- mem_regwrite  in  1.
REQ-005 Control inputs:
- branch_taken  in  1  EX-resolved taken branch or jump.
- md_start  in  1  mult/div accepted in EX.
REQ-006 Forwarding outputs, registered:
- fwd_a_mem, fwd_a_wb, fwd_b_mem, fwd_b_wb  out  1 each.
- Each drives the sel input of a 32-bit 2:1 operand mux in EX.
REQ-007 Pipeline-control outputs:
- pc_write, ifid_write, ifid_flush, idex_flush  out  1 each.
- md_busy  out  1.
- stall_cnt  out  16.

Function
REQ-008 A source match SHALL require all of: regwrite asserted, destination != 0, destination == source, and the matching uses_* bit set.
REQ-009 load_stall SHALL be combinational: ex_memread high and ex_rd matching rs or rt per REQ-008.
REQ-010 hilo_stall SHALL be combinational: state MD_BUSY and id_reads_hilo high.
REQ-011 stall SHALL equal (load_stall OR hilo_stall) AND NOT branch_taken.
REQ-012 pc_write and ifid_write SHALL both equal NOT stall.
REQ-013 idex_flush SHALL equal stall OR branch_taken.
REQ-014 ifid_flush SHALL equal branch_taken.
REQ-015 branch_taken SHALL have priority over every stall.
REQ-016 On each clock edge with idex_flush low, fwd_x_mem SHALL load the EX-stage match (ex_rd) for the source of operand x.
REQ-017 On each clock edge with idex_flush low, fwd_x_wb SHALL load the MEM-stage match (mem_rd) AND NOT the EX-stage match, so the youngest producer wins and the two bits are never both high.
REQ-018 On each clock edge with idex_flush high, all four fwd_* SHALL load 0, since the bubble forwards nothing.
REQ-019 FSM states SHALL be IDLE and MD_BUSY.
REQ-020 In IDLE, md_start SHALL load the down-counter with MD_LAT-1 and enter MD_BUSY.
REQ-021 In MD_BUSY, the counter SHALL decrement each cycle; at counter 0 the FSM returns to IDLE on the next edge.
REQ-022 md_start while in MD_BUSY SHALL reload the counter with MD_LAT-1 (restart); the state stays MD_BUSY.
REQ-023 md_busy SHALL be high exactly when the state is MD_BUSY.
REQ-024 stall_cnt SHALL increment on every cycle with stall high and SHALL saturate at 16'hFFFF (no wrap).
REQ-025 Combinational outputs SHALL have zero-cycle latency; fwd_* SHALL have one-cycle latency (ID decision, used in EX).

Reset
REQ-026 With rst_n low, regardless of clk, the block SHALL force:
- state IDLE and counter 0.
- all fwd_* low and stall_cnt 0.
- md_busy low.
REQ-027 During reset, combinational outputs SHALL follow inputs with state IDLE (pc_write = ifid_write = 1 when no load_stall).
REQ-028 Reset asserted mid-MD_BUSY SHALL abort the operation; no hilo_stall is raised afterwards.

Configuration
REQ-029 Macro HAZ_MULDIV_EN: when defined, REQ-010 and REQ-019..REQ-023 and REQ-028 SHALL be implemented.
REQ-030 When HAZ_MULDIV_EN is undefined:
- no FSM or counter exists.
- md_busy is tied 0 and hilo_stall is 0.
- md_start and id_reads_hilo are ignored.

Structure
REQ-031 A shared package SHALL hold the FSM state typedef, the zero-register constant (5'd0) and the stall_cnt width constant (16).
REQ-032 One sub-module, hazard_md_timer, SHALL contain the FSM and counter (REQ-019..REQ-023); it is instantiated only under HAZ_MULDIV_EN.

Verification
REQ-033 ex_regwrite=1, ex_rd=8, id_rs=8, id_uses_rs=1, edge -> fwd_a_mem=1, fwd_a_wb=0; fwd_b_* = 0.
REQ-034 EX and MEM both write reg 9, id_rt=9, id_uses_rt=1, edge -> fwd_b_mem=1, fwd_b_wb=0. Same setup with rd=0 -> both 0.
REQ-035 ex_memread=1, ex_rd=5, id_rs=5 -> same cycle pc_write=0, ifid_write=0, idex_flush=1. Next edge: fwd_* = 0 and stall_cnt=1. Adding branch_taken=1 -> pc_write=1, ifid_flush=1, idex_flush=1.
REQ-036 MD_LAT=4, md_start pulse at cycle 0 -> md_busy high for cycles 1..4. id_reads_hilo=1 stalls during cycles 1..4 and releases at cycle 5. md_start at cycle 2 extends md_busy through cycle 6.
REQ-037 rst_n low during MD_BUSY -> md_busy=0 immediately, with no clock; stall_cnt=0. Force 65540 stall cycles -> stall_cnt holds 16'hFFFF.
REQ-038 Build without HAZ_MULDIV_EN, md_start=1 and id_reads_hilo=1 -> md_busy=0, pc_write=1.
